// File: rtl/trap_sequencer_pkg.sv
// trap_sequencer_pkg: privilege, CSR, mstatus and trap-sequence types shared by the trap sequencer
package trap_sequencer_pkg;
  typedef enum logic [1:0] {
    USER       = 2'b00,
    SUPERVISOR = 2'b01,
    RESERVED   = 2'b10,
    MACHINE    = 2'b11
  } privilege_level_t;
  typedef enum logic [11:0] {
    CSR_MSTATUS = 12'h300,
    CSR_MEPC    = 12'h341,
    CSR_MCAUSE  = 12'h342,
    CSR_MTVAL   = 12'h343
  } csr_allocation_t;
  typedef enum logic [2:0] {
    IDLE,
    WR_MEPC,
    WR_MCAUSE,
    WR_MTVAL,
    WR_MSTATUS,
    RET_MSTATUS,
    REDIRECT
  } trap_state_t;
  typedef struct packed {
    logic             sd;
    logic [24:0]      wpri4;
    logic             mbe;
    logic             sbe;
    logic [1:0]       sxl;
    logic [1:0]       uxl;
    logic [8:0]       wpri3;
    logic             tsr;
    logic             tw;
    logic             tvm;
    logic             mxr;
    logic             sum;
    logic             mprv;
    logic [1:0]       xs;
    logic [1:0]       fs;
    privilege_level_t mpp;
    logic [1:0]       vs;
    logic             spp;
    logic             mpie;
    logic             ube;
    logic             spie;
    logic             wpri2;
    logic             mie;
    logic             wpri1;
    logic             sie;
    logic             wpri0;
  } rv64_xstatus_t;
  // index 0 is the highest-priority interrupt code
  localparam logic [6:0][3:0] IRQ_PRIO = {4'd13, 4'd5, 4'd1, 4'd9, 4'd7, 4'd3, 4'd11};
  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;
endpackage

// File: rtl/trap_sequencer_if.sv
// trap_sequencer_if: commit/CSR-side bundle of the trap sequencer
interface trap_sequencer_if #(parameter int MLEN = 64);
  import trap_sequencer_pkg::*;
  logic             exc_valid_i;
  logic [MLEN-2:0]  exc_code_i;
  logic [MLEN-1:0]  exc_pc_i;
  logic [MLEN-1:0]  exc_tval_i;
  logic             mret_valid_i;
  logic [MLEN-1:0]  mstatus_i;
  logic [MLEN-1:0]  mie_i;
  logic [MLEN-1:0]  mip_i;
  logic [MLEN-1:0]  mtvec_i;
  logic [MLEN-1:0]  mepc_i;
  logic             ack_o;
  logic             busy_o;
  logic             csr_we_o;
  logic [11:0]      csr_addr_o;
  logic [MLEN-1:0]  csr_wdata_o;
  logic             flush_o;
  logic             redirect_valid_o;
  logic [MLEN-1:0]  redirect_pc_o;
  privilege_level_t priv_o;
  modport master (
    output exc_valid_i, exc_code_i, exc_pc_i, exc_tval_i, mret_valid_i,
    output mstatus_i, mie_i, mip_i, mtvec_i, mepc_i,
    input  ack_o, busy_o, csr_we_o, csr_addr_o, csr_wdata_o,
    input  flush_o, redirect_valid_o, redirect_pc_o, priv_o
  );
  modport slave (
    input  exc_valid_i, exc_code_i, exc_pc_i, exc_tval_i, mret_valid_i,
    input  mstatus_i, mie_i, mip_i, mtvec_i, mepc_i,
    output ack_o, busy_o, csr_we_o, csr_addr_o, csr_wdata_o,
    output flush_o, redirect_valid_o, redirect_pc_o, priv_o
  );
endinterface

// File: rtl/trap_sequencer_irq_priority_select.sv
// irq_priority_select: picks the highest-priority pending interrupt code
module irq_priority_select
  import trap_sequencer_pkg::*;
#(
  parameter int MLEN = 64
) (
  input  logic [MLEN-1:0] pending_i,
  output logic            valid_o,
  output logic [3:0]      code_o
);
  // scan lowest priority first so the highest pending one is written last
  always_comb begin
    valid_o = 1'b0;
    code_o  = '0;
    for (int i = 6; i >= 0; i--) begin
      if (pending_i[IRQ_PRIO[i]]) begin
        valid_o = 1'b1;
        code_o  = IRQ_PRIO[i];
      end
    end
  end
endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap/MRET sequencer writing CSRs one per cycle, then flush and redirect
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int               MLEN       = 64,
  parameter privilege_level_t RESET_PRIV = MACHINE
) (
  input logic             clk_i,
  input logic             rst_i,
  trap_sequencer_if.slave bus
);
  trap_state_t      state_q, state_d;
  privilege_level_t priv_q, priv_d;
  logic             irq_q, ret_q;
  logic [MLEN-2:0]  code_q;
  logic [MLEN-1:0]  pc_q, tval_q, base;
  logic             irq_valid, irq_en, take_trap, ack;
  logic [3:0]       irq_code;
  rv64_xstatus_t    ms, ms_d;

  irq_priority_select #(.MLEN(MLEN)) u_sel (
    .pending_i(bus.mip_i & bus.mie_i),
    .valid_o  (irq_valid),
    .code_o   (irq_code)
  );

  assign ms        = rv64_xstatus_t'(bus.mstatus_i);
  assign irq_en    = irq_valid && (priv_q != MACHINE || ms.mie);
  assign take_trap = bus.exc_valid_i || irq_en;
  assign ack       = state_q == IDLE && (take_trap || bus.mret_valid_i);
  assign base      = bus.mtvec_i & ~MLEN'(3);
  assign bus.ack_o  = ack;
  assign bus.busy_o = state_q != IDLE;
  assign bus.priv_o = priv_q;

  // sequence state and privilege level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      priv_q  <= RESET_PRIV;
    end else begin
      state_q <= state_d;
      priv_q  <= priv_d;
    end
  end

  // capture the accepted event; exceptions override interrupts, traps override MRET
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q  <= 1'b0;
      ret_q  <= 1'b0;
      code_q <= '0;
      pc_q   <= '0;
      tval_q <= '0;
    end else if (ack) begin
      irq_q  <= !bus.exc_valid_i && irq_en;
      ret_q  <= !take_trap;
      code_q <= bus.exc_valid_i ? bus.exc_code_i : (MLEN-1)'(irq_code);
      pc_q   <= bus.exc_pc_i;
      tval_q <= bus.exc_tval_i;
    end
  end

  // next state, CSR write port and redirect outputs
  always_comb begin
    state_d              = state_q;
    priv_d               = priv_q;
    ms_d                 = ms;
    bus.csr_we_o         = 1'b0;
    bus.csr_addr_o       = '0;
    bus.csr_wdata_o      = '0;
    bus.flush_o          = 1'b0;
    bus.redirect_valid_o = 1'b0;
    bus.redirect_pc_o    = '0;
    case (state_q)
      IDLE: state_d = take_trap ? WR_MEPC : bus.mret_valid_i ? RET_MSTATUS : IDLE;
      WR_MEPC: begin
        state_d         = WR_MCAUSE;
        bus.csr_we_o    = 1'b1;
        bus.csr_addr_o  = CSR_MEPC;
        bus.csr_wdata_o = pc_q & ~MLEN'(1);
      end
      WR_MCAUSE: begin
        state_d         = WR_MTVAL;
        bus.csr_we_o    = 1'b1;
        bus.csr_addr_o  = CSR_MCAUSE;
        bus.csr_wdata_o = {irq_q, code_q};
      end
      WR_MTVAL: begin
        state_d         = WR_MSTATUS;
        bus.csr_we_o    = 1'b1;
        bus.csr_addr_o  = CSR_MTVAL;
        bus.csr_wdata_o = irq_q ? '0 : tval_q;
      end
      WR_MSTATUS: begin
        state_d         = REDIRECT;
        ms_d.mpie       = ms.mie;
        ms_d.mie        = 1'b0;
        ms_d.mpp        = priv_q;
        bus.csr_we_o    = 1'b1;
        bus.csr_addr_o  = CSR_MSTATUS;
        bus.csr_wdata_o = ms_d;
        priv_d          = MACHINE;
      end
      RET_MSTATUS: begin
        state_d         = REDIRECT;
        ms_d.mie        = ms.mpie;
        ms_d.mpie       = 1'b1;
        ms_d.mpp        = USER;
        bus.csr_we_o    = 1'b1;
        bus.csr_addr_o  = CSR_MSTATUS;
        bus.csr_wdata_o = ms_d;
        priv_d          = ms.mpp == RESERVED ? USER : ms.mpp;
      end
      REDIRECT: begin
        state_d              = IDLE;
        bus.flush_o          = 1'b1;
        bus.redirect_valid_o = 1'b1;
        bus.redirect_pc_o    = ret_q ? bus.mepc_i & ~MLEN'(1) :
                               (bus.mtvec_i[1:0] == MTVEC_MODE_VECTORED && irq_q) ?
                               base + {code_q[MLEN-3:0], 2'b00} : base;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Machine-mode trap controller between the pipeline's commit stage and the CSR file. It accepts a synchronous exception, a pending enabled interrupt, or an MRET. It then writes mepc, mcause, mtval and mstatus one CSR per cycle through the CSR file's single write port. It finishes by issuing a pipeline flush and a PC redirect, and it owns the current privilege level.

## Interface
Parameters:
- MLEN, 64, datapath / CSR width.
- RESET_PRIV, MACHINE, privilege level after reset (privilege_level_t).

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- exc_valid_i  in  1  committed instruction raised a synchronous exception.
- exc_code_i  in  MLEN-1  synchronous_exception_code_t.
- exc_pc_i  in  MLEN  PC of the faulting or interrupted instruction.
- exc_tval_i  in  MLEN  trap value.
- mret_valid_i  in  1  committed MRET.
- mstatus_i, mie_i, mip_i, mtvec_i, mepc_i  in  MLEN each  current CSR values.
- ack_o  out  1  event accepted this cycle.
- busy_o  out  1  sequence in progress.
- csr_we_o  out  1  CSR write strobe.
- csr_addr_o  out  12  csr_allocation_t target.
- csr_wdata_o  out  MLEN  write data.
- flush_o  out  1  flush the pipeline.
- redirect_valid_o  out  1  fetch redirect strobe.
- redirect_pc_o  out  MLEN  redirect target.
- priv_o  out  2  current privilege level.

## Operation
- Event selection in IDLE, highest priority first: exc_valid_i, then an enabled interrupt, then mret_valid_i. The selected event is latched together with the pc, cause and tval; ack_o=1 that cycle.
- An interrupt is enabled when (mip_i & mie_i) is nonzero and (priv_o != MACHINE or mstatus.mie=1).
- Interrupt priority when several are enabled: 11, 3, 7, 9, 1, 5, 13. All traps go to M-mode; medeleg and mideleg are ignored.
- Trap state sequence: IDLE, then WR_MEPC, then WR_MCAUSE, then WR_MTVAL, then WR_MSTATUS, then REDIRECT, then back to IDLE.
- MRET state sequence: IDLE, then RET_MSTATUS, then REDIRECT, then back to IDLE.
- mepc write data: {pc[MLEN-1:1], 1'b0}.
- mcause write data: {interrupt, code} with interrupt in bit MLEN-1. Synchronous codes are zero-extended.
- mtval write data: the latched tval for exceptions, 0 for interrupts.
- Trap mstatus update: mpie←mie, mie←0, mpp←priv_o; all other fields pass through from mstatus_i as sampled in WR_MSTATUS. priv_o becomes MACHINE.
- MRET mstatus update: mie←mpie, mpie←1, mpp←USER. priv_o becomes the old mpp; a RESERVED mpp maps to USER.
- Trap target: base = {mtvec[MLEN-1:2], 2'b00}.
  - mtvec mode 01 (vectored) with an interrupt: base + 4×code, with MLEN-bit wrap-around.
  - Otherwise (direct, or reserved modes 1x): base.
- MRET target: {mepc_i[MLEN-1:1], 1'b0}, sampled in REDIRECT.
- While busy_o=1, all inputs are ignored and nothing is latched. Upstream holds commit until the flush.
- Reset in any state returns the block to IDLE immediately. No further CSR write or redirect is issued, and priv_o←RESET_PRIV.

## Timing
- Reset values: ack_o, busy_o, csr_we_o, flush_o and redirect_valid_o are 0; csr_addr_o, csr_wdata_o and redirect_pc_o are 0; priv_o=RESET_PRIV.
- ack_o is combinational from IDLE and the inputs. All other outputs are driven from registered state.
- Trap accepted in cycle N:
  - csr_we_o=1 in cycles N+1 (mepc), N+2 (mcause), N+3 (mtval) and N+4 (mstatus).
  - flush_o, redirect_valid_o and the redirect PC in cycle N+5.
  - priv_o changes at the end of cycle N+4.
- MRET accepted in cycle N: mstatus write in cycle N+1; flush and redirect in cycle N+2; priv_o changes at the end of cycle N+1.
- busy_o=1 from N+1 through the REDIRECT cycle inclusive.
- A new event can be accepted in the cycle after REDIRECT.
- flush_o and redirect_valid_o are single-cycle pulses.

## Structure
- Additions to riscv_privileged_pkg:
  - trap_state_t enum.
  - Interrupt priority order constant.
  - MTVEC_MODE_DIRECT = 2'b00 and MTVEC_MODE_VECTORED = 2'b01.
- Use rv64_xstatus_t casts for the mstatus field edits.
- One natural sub-module: irq_priority_select, a combinational pending-mask-to-code encoder.

## Test plan
- Illegal instruction (code 2) at pc 0x8000_0100, tval 0xDEAD, priv USER, mtvec 0x8000_0000: writes mepc=0x8000_0100, mcause=2, mtval=0xDEAD, then mstatus with mpp=00 and mie=0. Redirect to 0x8000_0000 at N+5; priv_o=11.
- MTI pending and enabled, mstatus.mie=1, priv MACHINE, mtvec 0x8000_0001: mcause=0x8000_0000_0000_0007, mtval=0, redirect to 0x8000_001C.
- MEI and MTI pending together: mcause code 11.
- With mstatus.mie=0 and priv MACHINE, a pending interrupt is not taken.
- exc_valid_i, an enabled interrupt and mret_valid_i all asserted in the same cycle: the exception wins. Events arriving while busy_o=1 are ignored.
- MRET with mpp=01, mpie=1, mepc 0x8000_0203: mstatus write has mie=1, mpie=1, mpp=00; redirect to 0x8000_0202 at N+2; priv_o=01.
- rst_i asserted during WR_MCAUSE: no further csr_we_o, no redirect, priv_o=RESET_PRIV. The next exception runs the full sequence normally.
